// File: rtl/signed_seg_scanner_pkg.sv
// Shared definitions for the signed 7-segment scanner: active-low segment
// patterns, the digit encoder and the conversion FSM state type.
package seg_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0011000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;

   typedef enum logic {S_IDLE, S_CONV} state_t;

   // Codes above 9 cannot come out of a valid BCD digit, so they show blank.
   function automatic logic [6:0] seg_encode(input logic [3:0] code);
      logic [6:0] pattern;
      pattern = SEG_BLANK;
      case (code)
         4'd0: pattern = SEG_0;
         4'd1: pattern = SEG_1;
         4'd2: pattern = SEG_2;
         4'd3: pattern = SEG_3;
         4'd4: pattern = SEG_4;
         4'd5: pattern = SEG_5;
         4'd6: pattern = SEG_6;
         4'd7: pattern = SEG_7;
         4'd8: pattern = SEG_8;
         4'd9: pattern = SEG_9;
         default: pattern = SEG_BLANK;
      endcase
      return pattern;
   endfunction

endpackage

// File: rtl/signed_seg_scanner_if.sv
// Load/status/display bundle between the ALU side and the scanner.
interface signed_seg_scanner_if;

   logic signed [9:0] value;
   logic              load;
   logic              busy;
   logic [6:0]        seg;
   logic [3:0]        an;

   modport master (output value, load, input busy, seg, an);
   modport slave  (input value, load, output busy, seg, an);

endinterface

// File: rtl/signed_seg_scanner_bcd_core.sv
// Iterative double-dabble: converts a 10-bit magnitude to three BCD digits,
// one add-3/shift step per clock, ten steps after start.
module bcd_serial_core (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [9:0] mag,
   output logic       done,
   output logic [3:0] hund,
   output logic [3:0] tens,
   output logic [3:0] ones
);

   logic       active_q, active_d;
   logic [3:0] cnt_q, cnt_d;
   logic [9:0] shift_q, shift_d;
   logic [3:0] hund_q, hund_d;
   logic [3:0] tens_q, tens_d;
   logic [3:0] ones_q, ones_d;

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   always_comb begin
      active_d = active_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      hund_d   = hund_q;
      tens_d   = tens_q;
      ones_d   = ones_q;
      done     = 1'b0;
      if (start) begin
         active_d = 1'b1;
         cnt_d    = 4'd9;
         shift_d  = mag;
         hund_d   = 4'd0;
         tens_d   = 4'd0;
         ones_d   = 4'd0;
      end else if (active_q) begin
         {hund_d, tens_d, ones_d, shift_d} =
            {add3(hund_q), add3(tens_q), add3(ones_q), shift_q} << 1;
         cnt_d = cnt_q - 4'd1;
         if (cnt_q == 4'd0) begin
            active_d = 1'b0;
            done     = 1'b1;
         end
      end
   end

   // Digits are exposed as this cycle's step result so the parent can commit
   // them on the very edge that performs the final step.
   assign hund = hund_d;
   assign tens = tens_d;
   assign ones = ones_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_q <= 1'b0;
         cnt_q    <= 4'd0;
         shift_q  <= 10'd0;
         hund_q   <= 4'd0;
         tens_q   <= 4'd0;
         ones_q   <= 4'd0;
      end else begin
         active_q <= active_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         hund_q   <= hund_d;
         tens_q   <= tens_d;
         ones_q   <= ones_d;
      end
   end

endmodule

// File: rtl/signed_seg_scanner.sv
// Captures a signed ALU result, converts its magnitude to BCD serially and
// scans sign/hundreds/tens/ones onto one shared active-low segment bus.
module signed_seg_scanner
   import seg_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter bit BLANK_LEAD  = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   signed_seg_scanner_if.slave  bus
);

   localparam int                PRESC_W   = $clog2(REFRESH_DIV);
   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(REFRESH_DIV - 1);

   state_t               state_q, state_d;
   logic                 busy_q, busy_d;
   logic                 sign_q, sign_d;
   logic                 disp_sign_q, disp_sign_d;
   logic [3:0]           disp_hund_q, disp_hund_d;
   logic [3:0]           disp_tens_q, disp_tens_d;
   logic [3:0]           disp_ones_q, disp_ones_d;
   logic [PRESC_W-1:0]   presc_q, presc_d;
   logic [1:0]           idx_q, idx_d;
   logic [6:0]           seg_q, seg_d;
   logic [3:0]           an_q, an_d;

   logic [9:0]           value_u;
   logic [9:0]           mag;
   logic                 start;
   logic                 core_done;
   logic [3:0]           core_hund, core_tens, core_ones;
   logic                 hund_blank, tens_blank;

   // -512 negates to itself in 10 bits, which read unsigned is exactly 512.
   assign value_u = bus.value;
   assign mag     = value_u[9] ? (~value_u + 10'd1) : value_u;
   assign start   = (state_q == S_IDLE) && bus.load;

   bcd_serial_core u_core (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .mag   (mag),
      .done  (core_done),
      .hund  (core_hund),
      .tens  (core_tens),
      .ones  (core_ones)
   );

   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      sign_d      = sign_q;
      disp_sign_d = disp_sign_q;
      disp_hund_d = disp_hund_q;
      disp_tens_d = disp_tens_q;
      disp_ones_d = disp_ones_q;
      presc_d     = presc_q + PRESC_W'(1);
      idx_d       = idx_q;
      seg_d       = SEG_BLANK;

      case (state_q)
         S_IDLE: begin
            if (bus.load) begin
               sign_d  = value_u[9];
               busy_d  = 1'b1;
               state_d = S_CONV;
            end
         end
         S_CONV: begin
            if (core_done) begin
               disp_sign_d = sign_q;
               disp_hund_d = core_hund;
               disp_tens_d = core_tens;
               disp_ones_d = core_ones;
               busy_d      = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (presc_q == PRESC_MAX) begin
         presc_d = '0;
         idx_d   = idx_q + 2'd1;
      end

      hund_blank = BLANK_LEAD && (disp_hund_q == 4'd0);
      tens_blank = hund_blank && (disp_tens_q == 4'd0);

      case (idx_q)
         2'd0: seg_d = seg_encode(disp_ones_q);
         2'd1: seg_d = tens_blank ? SEG_BLANK : seg_encode(disp_tens_q);
         2'd2: seg_d = hund_blank ? SEG_BLANK : seg_encode(disp_hund_q);
         2'd3: seg_d = disp_sign_q ? SEG_MINUS : SEG_BLANK;
         default: seg_d = SEG_BLANK;
      endcase
      an_d = ~(4'b0001 << idx_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         sign_q      <= 1'b0;
         disp_sign_q <= 1'b0;
         disp_hund_q <= 4'd0;
         disp_tens_q <= 4'd0;
         disp_ones_q <= 4'd0;
         presc_q     <= '0;
         idx_q       <= 2'd0;
         seg_q       <= SEG_0;
         an_q        <= 4'b1110;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         sign_q      <= sign_d;
         disp_sign_q <= disp_sign_d;
         disp_hund_q <= disp_hund_d;
         disp_tens_q <= disp_tens_d;
         disp_ones_q <= disp_ones_d;
         presc_q     <= presc_d;
         idx_q       <= idx_d;
         seg_q       <= seg_d;
         an_q        <= an_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.seg  = seg_q;
   assign bus.an   = an_q;

endmodule
